// File: rtl/dcs_gram_wgt_engine.sv
// Gram-matrix / weighted-sum engine: streams A (N x D), builds S = A*A^T,
// optionally zeroes entries not above their row mean, then streams y = S*w.
module dcs_gram_wgt_engine #(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int SW = 2*DW + $clog2(D),
  parameter int OW = SW + WW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          thr_en,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [WW-1:0] w_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          busy
);
  localparam int NL = $clog2(N);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int MW = SW + NL;

  localparam logic [NL:0]   PC_N     = (NL+1)'(N);
  localparam logic [NL:0]   PC_LAST  = (NL+1)'(N-1);
  localparam logic [NL-1:0] ROW_LAST = NL'(N-1);
  localparam logic [CW-1:0] COL_LAST = CW'(D-1);

  typedef enum logic [2:0] {IDLE, LOAD, GRAM_FLUSH, MEAN, THR, WGT, DRAIN, OUT} state_t;

  state_t state, state_nxt;
  logic [NL:0]   pcnt;
  logic [NL-1:0] pidx;
  logic [NL-1:0] row;
  logic [CW-1:0] col;
  logic          thr_q, busy_q;

  logic          g_v;
  logic [NL-1:0] g_r;
  logic [CW-1:0] g_c;
  logic [DW-1:0] g_x;

  logic          w_v;
  logic [NL-1:0] w_k;
  logic [WW-1:0] w_x;

  logic [DW-1:0] abuf [N][D];
  logic [SW-1:0] s    [N][N];
  logic [MW-1:0] sums [N];
  logic [SW-1:0] mean [N];
  logic [OW-1:0] y    [N];
  logic [SW-1:0] gprod [N];
  logic [OW-1:0] wprod [N];

  logic i_acc, w_acc, o_acc, last_a, clr;

  assign pidx    = pcnt[NL-1:0];
  assign i_ready = (state == LOAD);
  assign w_ready = (state == WGT);
  assign o_valid = (state == OUT);
  assign o_data  = o_valid ? y[pidx] : '0;
  assign busy    = busy_q;
  assign i_acc   = i_valid && i_ready;
  assign w_acc   = w_valid && w_ready;
  assign o_acc   = o_valid && o_ready;
  assign last_a  = (row == ROW_LAST) && (col == COL_LAST);
  assign clr     = o_acc && (pcnt == PC_LAST);

  // Operands are widened before the multiply so products are never truncated.
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      gprod[j] = SW'(g_x) * SW'(abuf[j][g_c]);
      wprod[j] = OW'(s[j][w_k]) * OW'(w_x);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = LOAD;
      LOAD:       if (i_acc && last_a) state_nxt = GRAM_FLUSH;
      GRAM_FLUSH: if (!g_v) state_nxt = thr_q ? MEAN : WGT;
      MEAN:       if (pcnt == PC_N) state_nxt = THR;
      THR:        if (pcnt == PC_LAST) state_nxt = WGT;
      WGT:        if (w_acc && (pcnt == PC_LAST)) state_nxt = DRAIN;
      DRAIN:      state_nxt = OUT;
      OUT:        if (clr) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        pcnt <= '0;
      else if ((state == MEAN) || (state == THR) || w_acc || o_acc)
        pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abuf <= '{default: '0};
      s    <= '{default: '0};
      sums <= '{default: '0};
      mean <= '{default: '0};
      y    <= '{default: '0};
      row <= '0; col <= '0; thr_q <= 1'b0; busy_q <= 1'b0;
      g_v <= 1'b0; g_r <= '0; g_c <= '0; g_x <= '0;
      w_v <= 1'b0; w_k <= '0; w_x <= '0;
    end else if (clr) begin
      abuf <= '{default: '0};
      s    <= '{default: '0};
      sums <= '{default: '0};
      mean <= '{default: '0};
      y    <= '{default: '0};
      row <= '0; col <= '0; thr_q <= 1'b0; busy_q <= 1'b0;
      g_v <= 1'b0; w_v <= 1'b0;
    end else begin
      g_v <= 1'b0;
      w_v <= 1'b0;
      if (i_acc) begin
        abuf[row][col] <= i_data;
        g_v <= 1'b1; g_r <= row; g_c <= col; g_x <= i_data;
        if ((row == '0) && (col == '0)) begin
          thr_q  <= thr_en;
          busy_q <= 1'b1;
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Registered beat meets every earlier row in the same column; the
      // beat itself is already in abuf, so j == g_r yields the square term.
      if (g_v) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (NL'(j) <= g_r) begin
            s[j][g_r] <= s[j][g_r] + gprod[j];
            if (NL'(j) != g_r) s[g_r][j] <= s[g_r][j] + gprod[j];
          end
        end
      end
      if (state == MEAN) begin
        for (int unsigned r = 0; r < N; r++) begin
          if (pcnt != PC_N) sums[r] <= sums[r] + MW'(s[pidx][r]);
          else              mean[r] <= SW'(sums[r] >> NL);
        end
      end
      if (state == THR) begin
        for (int unsigned c = 0; c < N; c++)
          if (s[pidx][c] <= mean[pidx]) s[pidx][c] <= '0;
      end
      if (w_acc) begin
        w_v <= 1'b1; w_k <= pidx; w_x <= w_data;
      end
      if (w_v) begin
        for (int unsigned i = 0; i < N; i++) y[i] <= y[i] + wprod[i];
      end
    end
  end
endmodule

// File: tb/tb_dcs_gram_wgt_engine.sv
// Randomised self-checking bench for dcs_gram_wgt_engine against a
// matrix-level reference model.
module tb_dcs_gram_wgt_engine;
  localparam int N  = 8;
  localparam int D  = 16;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int SW = 2*DW + $clog2(D);
  localparam int OW = SW + WW + $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW-1:0] i_data = '0;
  logic          thr_en = 1'b0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [WW-1:0] w_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [OW-1:0] o_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned     a_mat [N][D];
  int unsigned     w_vec [N];
  longint unsigned exp_y [N];

  dcs_gram_wgt_engine #(.N(N), .D(D), .DW(DW), .WW(WW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .thr_en(thr_en),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void compute_model(input bit thr);
    longint unsigned sm [N][N];
    longint unsigned m [N];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sm[r][c] = 0;
        for (int k = 0; k < D; k++) sm[r][c] += longint'(a_mat[r][k]) * a_mat[c][k];
      end
    if (thr) begin
      for (int r = 0; r < N; r++) begin
        m[r] = 0;
        for (int j = 0; j < N; j++) m[r] += sm[j][r];
        m[r] = m[r] / N;
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (!(sm[r][c] > m[r])) sm[r][c] = 0;
    end
    for (int i = 0; i < N; i++) begin
      exp_y[i] = 0;
      for (int k = 0; k < N; k++) exp_y[i] += sm[i][k] * w_vec[k];
    end
  endfunction

  task automatic send_a(input bit thr, input int gap, input int nbeats);
    check("busy_idle", busy, 0);
    for (int k = 0; k < nbeats; k++) begin
      int guard = 0;
      i_valid = 1'b1;
      i_data  = DW'(a_mat[k/D][k%D]);
      thr_en  = (k == 0) ? thr : 1'($urandom_range(0, 1));
      w_valid = (k < N*D-1);
      w_data  = WW'($urandom);
      while (!i_ready && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      if (!i_ready) begin
        check("i_ready_timeout", i_ready, 1);
        i_valid = 1'b0; w_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (k == 0) check("busy_start", busy, 1);
      i_valid = 1'b0;
      w_valid = 1'b0;
      if (gap > 0 && (k+1) % gap == 0)
        repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_w();
    int n = 0;
    for (int k = 0; k < N; k++) begin
      int guard = 0;
      w_valid = 1'b1;
      w_data  = WW'(w_vec[k]);
      i_valid = 1'b1;
      i_data  = DW'($urandom);
      while (!w_ready && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      if (!w_ready) begin
        check("w_ready_timeout", w_ready, 1);
        w_valid = 1'b0; i_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    i_valid = 1'b0;
    while (!o_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("latency_le4", (n <= 4), 1);
  endtask

  // mode 0: always ready, 1: stall 3 cycles on y[1], 2: random backpressure
  task automatic collect(input int mode);
    int idx = 0, stall = 0, guard = 0;
    bit was_stalled = 0;
    while (idx < N && guard < 1000) begin
      if (mode == 0)      o_ready = 1'b1;
      else if (mode == 1) o_ready = !(idx == 1 && stall < 3);
      else                o_ready = ($urandom_range(0, 3) != 0);
      if (was_stalled) begin
        check("hold_valid", o_valid, 1);
        check($sformatf("hold_y%0d", idx), o_data, exp_y[idx]);
      end
      was_stalled = 0;
      if (o_valid) begin
        if (o_ready) begin
          check($sformatf("y%0d", idx), o_data, exp_y[idx]);
          idx++;
        end else begin
          was_stalled = 1;
          if (mode == 1 && idx == 1) stall++;
        end
      end
      @(posedge clk); #1; guard++;
    end
    if (idx < N) check("out_timeout", idx, N);
    o_ready = 1'b0;
    check("end_valid", o_valid, 0);
    check("end_data", o_data, 0);
    check("busy_end", busy, 0);
    @(posedge clk); #1;
    check("i_ready_after", i_ready, 1);
  endtask

  task automatic run_frame(input bit thr, input int gap, input int omode);
    compute_model(thr);
    send_a(thr, gap, N*D);
    send_w();
    collect(omode);
  endtask

  task automatic fill_a(input int kind, input int unsigned maxv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < D; c++)
        case (kind)
          0: a_mat[r][c] = 1;
          1: a_mat[r][c] = (r == c) ? 1 : 0;
          2: a_mat[r][c] = 255;
          default: a_mat[r][c] = $urandom_range(0, maxv);
        endcase
  endtask

  task automatic check_reset_outputs();
    check("rst_i_ready", i_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    check("i_ready_at_release", i_ready, 0);
    @(posedge clk); #1;
    check("i_ready_post_release", i_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();

    fill_a(0, 0);
    for (int k = 0; k < N; k++) w_vec[k] = 1;
    run_frame(1, 0, 0);
    run_frame(0, 0, 0);

    fill_a(1, 0);
    for (int k = 0; k < N; k++) w_vec[k] = k + 1;
    run_frame(1, 0, 0);

    fill_a(2, 0);
    for (int k = 0; k < N; k++) w_vec[k] = 255;
    run_frame(0, 0, 0);

    fill_a(3, 255);
    for (int k = 0; k < N; k++) w_vec[k] = $urandom_range(0, 255);
    run_frame(0, 0, 1);
    run_frame(0, 5, 1);

    fill_a(3, 255);
    send_a(1, 0, 40);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    release_reset();
    fill_a(1, 0);
    for (int k = 0; k < N; k++) w_vec[k] = k + 1;
    run_frame(1, 0, 0);

    for (int f = 0; f < 4; f++) begin
      fill_a(3, (f % 2 == 0) ? 3 : 255);
      for (int k = 0; k < N; k++) w_vec[k] = $urandom_range(0, 255);
      run_frame(1'($urandom_range(0, 1)), (f == 1) ? 3 : 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
